// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D-cache memory arbiter and its integrators.
package mem_arbiter_pkg;

  // Default block address width and memory block width
  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) round-robin arbiter in front of a single
// block memory port. One transaction in flight; request fields are latched
// at grant and held on the memory side until mem_ready.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  // I-cache port
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  // D-cache port
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  // Memory port
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_e        state_q;
  logic              last_d_q;     // 1: D was served most recently
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic d_req;
  logic grant_d;
  logic grant_i;

  // Grant decision in IDLE: D wins when alone or when I was served last
  always_comb begin
    d_req   = d_mem_read | d_mem_write;
    grant_d = (state_q == IDLE) && d_req && (!i_mem_read || !last_d_q);
    grant_i = (state_q == IDLE) && i_mem_read && !grant_d;
  end

  // Arbiter FSM with registered memory-side request
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q     <= BUSY_D;
            last_d_q    <= 1'b1;
            // read+write together is treated as a write
            mem_write_q <= d_mem_write;
            mem_read_q  <= ~d_mem_write;
            mem_addr_q  <= d_mem_addr;
            mem_wdata_q <= d_mem_wdata;
          end else if (grant_i) begin
            state_q     <= BUSY_I;
            last_d_q    <= 1'b0;
            mem_read_q  <= 1'b1;
            mem_write_q <= 1'b0;
            mem_addr_q  <= i_mem_addr;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready) begin
            state_q     <= DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        // One dead cycle hides the just-served client's stale request
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Completion is steered combinationally to the client being served
  always_comb begin
    i_mem_ready = (state_q == BUSY_I) && mem_ready;
    d_mem_ready = (state_q == BUSY_D) && mem_ready;
    i_mem_rdata = mem_rdata;
    d_mem_rdata = mem_rdata;
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// client/memory traffic compared against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = DEF_ADDR_W;
  localparam int DW = DEF_DATA_W;

  logic          clk = 1'b0;
  logic          proc_reset_n;
  logic          i_mem_read;
  logic [AW-1:0] i_mem_addr;
  logic [DW-1:0] i_mem_rdata;
  logic          i_mem_ready;
  logic          d_mem_read;
  logic          d_mem_write;
  logic [AW-1:0] d_mem_addr;
  logic [DW-1:0] d_mem_wdata;
  logic [DW-1:0] d_mem_rdata;
  logic          d_mem_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .i_mem_read   (i_mem_read),
    .i_mem_addr   (i_mem_addr),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_ready  (i_mem_ready),
    .d_mem_read   (d_mem_read),
    .d_mem_write  (d_mem_write),
    .d_mem_addr   (d_mem_addr),
    .d_mem_wdata  (d_mem_wdata),
    .d_mem_rdata  (d_mem_rdata),
    .d_mem_ready  (d_mem_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction, a one-cycle cool-down after
  // each completion, round-robin between clients when both are waiting.
  bit            m_busy;
  bit            m_isd;
  bit            m_wr;
  bit            m_last_d;
  int            m_cool;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  function automatic void model_reset();
    m_busy   = 1'b0;
    m_isd    = 1'b0;
    m_wr     = 1'b0;
    m_last_d = 1'b0;
    m_cool   = 0;
    m_addr   = '0;
    m_wdata  = '0;
  endfunction

  function automatic void model_step();
    bit want_i;
    bit want_d;
    bit pick_d;
    if (!proc_reset_n) begin
      model_reset();
      return;
    end
    want_i = i_mem_read;
    want_d = d_mem_read | d_mem_write;
    if (m_busy) begin
      if (mem_ready) begin
        m_busy = 1'b0;
        m_cool = 1;
      end
    end else if (m_cool > 0) begin
      m_cool = m_cool - 1;
    end else if (want_i || want_d) begin
      pick_d   = want_d && !(want_i && m_last_d);
      m_busy   = 1'b1;
      m_isd    = pick_d;
      m_last_d = pick_d;
      if (pick_d) begin
        m_wr    = d_mem_write;
        m_addr  = d_mem_addr;
        m_wdata = d_mem_wdata;
      end else begin
        m_wr   = 1'b0;
        m_addr = i_mem_addr;
      end
    end
  endfunction

  int  cyc = 0;
  int  n_rd, n_irdy, n_drdy;
  int  t_irdy, t_drdy;
  bit  i_seen, d_seen;
  byte glog[$];

  // One clock cycle: inputs are already set; check, observe, advance.
  task automatic tick();
    #1;
    cyc++;
    chk("mem_read",  mem_read,  m_busy && !m_wr);
    chk("mem_write", mem_write, m_busy && m_wr);
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("i_ready",   i_mem_ready, m_busy && !m_isd && mem_ready);
    chk("d_ready",   d_mem_ready, m_busy && m_isd && mem_ready);
    chk("i_rdata",   i_mem_rdata, mem_rdata);
    chk("d_rdata",   d_mem_rdata, mem_rdata);
    chk("rdy_excl",  i_mem_ready & d_mem_ready, 1'b0);
    i_seen = i_mem_ready;
    d_seen = d_mem_ready;
    if (mem_read) n_rd++;
    if (i_mem_ready) begin n_irdy++; t_irdy = cyc; glog.push_back("I"); end
    if (d_mem_ready) begin n_drdy++; t_drdy = cyc; glog.push_back("D"); end
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_mem_read  = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    mem_ready   = 1'b0;
  endtask

  task automatic pulse_reset();
    clear_inputs();
    proc_reset_n = 1'b0;
    model_reset();
    tick();
    proc_reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ip, dp;
    int ty;
    proc_reset_n = 1'b0;
    clear_inputs();
    i_mem_addr  = '0;
    d_mem_addr  = '0;
    d_mem_wdata = '0;
    mem_rdata   = '0;
    model_reset();
    i_seen = 1'b0;
    d_seen = 1'b0;
    @(negedge clk);

    // Reset state
    #1;
    chk("rst_mem_read",  mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr",  mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_i_ready",   i_mem_ready, 1'b0);
    chk("rst_d_ready",   d_mem_ready, 1'b0);
    tick();
    proc_reset_n = 1'b1;

    // Simultaneous I and D reads right after reset: D first, one DONE gap
    glog.delete();
    i_mem_read = 1'b1; i_mem_addr = 28'h0000111;
    d_mem_read = 1'b1; d_mem_addr = 28'h0000222;
    for (int k = 0; k < 40 && (i_mem_read || d_mem_read); k++) begin
      if (i_seen) i_mem_read = 1'b0;
      if (d_seen) d_mem_read = 1'b0;
      mem_ready = mem_read | mem_write;
      tick();
    end
    chk("r031_timeout", {i_mem_read, d_mem_read}, 2'b00);
    chk("r031_count", glog.size(), 2);
    if (glog.size() >= 2) begin
      chk("r031_first",  glog[0], "D");
      chk("r031_second", glog[1], "I");
    end
    chk("r031_gap", t_irdy - t_drdy, 3);
    clear_inputs();
    tick();

    // I read, memory ready on the third busy cycle
    n_rd = 0; n_irdy = 0; n_drdy = 0;
    i_mem_read = 1'b1; i_mem_addr = 28'h0000010;
    tick();
    tick();
    tick();
    mem_ready = 1'b1;
    mem_rdata = {16{8'hA5}};
    #1;
    chk("r030_addr",  mem_addr, 28'h0000010);
    chk("r030_irdy",  i_mem_ready, 1'b1);
    chk("r030_rdata", i_mem_rdata, {16{8'hA5}});
    tick();
    clear_inputs();
    tick();
    tick();
    chk("r030_rd_cycles", n_rd, 3);
    chk("r030_irdy_cnt",  n_irdy, 1);
    chk("r030_drdy_cnt",  n_drdy, 0);

    // D read+write together is a write
    d_mem_read = 1'b1; d_mem_write = 1'b1;
    d_mem_addr = 28'h0ABCDEF; d_mem_wdata = {4{32'h12341234}};
    tick();
    #1;
    chk("r032_write", mem_write, 1'b1);
    chk("r032_read",  mem_read, 1'b0);
    chk("r032_wdata", mem_wdata, {4{32'h12341234}});
    chk("r032_addr",  mem_addr, 28'h0ABCDEF);
    mem_ready = 1'b1;
    tick();
    clear_inputs();
    tick();
    tick();

    // Address change while busy is ignored
    d_mem_read = 1'b1; d_mem_addr = 28'h1;
    tick();
    d_mem_addr = 28'h2;
    tick();
    #1;
    chk("r033_addr_a", mem_addr, 28'h1);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("r033_addr_b", mem_addr, 28'h1);
    chk("r033_drdy",   d_mem_ready, 1'b1);
    tick();
    clear_inputs();
    tick();
    tick();

    // Reset during BUSY_I, then a spurious mem_ready
    i_mem_read = 1'b1; i_mem_addr = 28'h0000345;
    tick();
    tick();
    proc_reset_n = 1'b0;
    #1;
    chk("r034_mem_read",  mem_read, 1'b0);
    chk("r034_mem_write", mem_write, 1'b0);
    chk("r034_mem_addr",  mem_addr, '0);
    chk("r034_mem_wdata", mem_wdata, '0);
    chk("r034_i_ready",   i_mem_ready, 1'b0);
    model_reset();
    i_mem_read = 1'b0;
    tick();
    proc_reset_n = 1'b1;
    n_irdy = 0; n_drdy = 0;
    mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    chk("r034_no_irdy", n_irdy, 0);
    chk("r034_no_drdy", n_drdy, 0);

    // Both ports request continuously: grants alternate starting with D
    pulse_reset();
    glog.delete();
    i_mem_read = 1'b1;
    d_mem_read = 1'b1;
    for (int k = 0; k < 60 && glog.size() < 6; k++) begin
      mem_ready  = mem_read | mem_write;
      i_mem_addr = AW'($urandom());
      d_mem_addr = AW'($urandom());
      tick();
    end
    chk("r035_count", glog.size(), 6);
    for (int k = 0; k < 6 && k < glog.size(); k++)
      chk("r035_order", glog[k], (k % 2 == 0) ? "D" : "I");
    clear_inputs();
    tick();
    tick();

    // Randomized traffic against the reference model
    ip = 1'b0;
    dp = 1'b0;
    ty = 0;
    for (int c = 0; c < 600; c++) begin
      if (i_seen) ip = 1'b0;
      if (d_seen) dp = 1'b0;
      if (!ip && $urandom_range(2) == 0) begin
        ip = 1'b1;
        i_mem_addr = AW'($urandom());
      end else if (ip && $urandom_range(3) == 0) begin
        i_mem_addr = AW'($urandom());
      end
      if (!dp && $urandom_range(2) == 0) begin
        dp = 1'b1;
        ty = $urandom_range(2);
        d_mem_addr  = AW'($urandom());
        d_mem_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else if (dp && $urandom_range(3) == 0) begin
        d_mem_addr  = AW'($urandom());
        d_mem_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      i_mem_read  = ip;
      d_mem_read  = dp && (ty != 1);
      d_mem_write = dp && (ty != 0);
      mem_ready   = ($urandom_range(2) == 0);
      mem_rdata   = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, meaning block address width.
REQ-002 SHALL have parameter DATA_W, default 128, meaning memory block width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; proc_reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have i_mem_read  input  1  I-cache read request, held until its ready.
REQ-005 SHALL have i_mem_addr  input  ADDR_W  I-cache block address.
REQ-006 SHALL have i_mem_rdata  output  DATA_W  read data to I-cache.
REQ-007 SHALL have i_mem_ready  output  1  I-cache completion.
REQ-008 SHALL have d_mem_read, d_mem_write  input  1 each  D-cache requests.
REQ-009 SHALL have d_mem_addr  input  ADDR_W, d_mem_wdata  input  DATA_W  D-cache address and write data.
REQ-010 SHALL have d_mem_rdata  output  DATA_W, d_mem_ready  output  1  D-cache return.
REQ-011 SHALL have mem_read, mem_write  output  1 each; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  memory request.
REQ-012 SHALL have mem_rdata  input  DATA_W; mem_ready  input  1  memory completion.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, DONE.
REQ-014 In IDLE with only I request pending: go to BUSY_I next edge; latch i_mem_addr.
REQ-015 In IDLE with only D request pending: go to BUSY_D next edge; latch d_mem_addr, d_mem_wdata, and request type.
REQ-016 In IDLE with both pending: grant the port not served last (round-robin); after reset, D wins first.
REQ-017 D request with d_mem_read and d_mem_write both high SHALL be latched as a write (mem_write=1, mem_read=0).
REQ-018 mem_read/mem_write/mem_addr/mem_wdata SHALL be registered; they assert the cycle after grant and hold constant until mem_ready.
REQ-019 Client inputs changing while BUSY_x SHALL be ignored.
REQ-020 mem_ready in BUSY_x: x_mem_ready=1 in the same cycle (combinational); mem_read/mem_write drop next edge; state goes to DONE.
REQ-021 DONE SHALL last exactly one cycle, grant nothing, then go to IDLE; this masks the served client's stale request.
REQ-022 mem_rdata SHALL be broadcast combinationally to i_mem_rdata and d_mem_rdata at all times.
REQ-023 i_mem_ready and d_mem_ready SHALL never be high together; each SHALL be 0 outside its own BUSY state.
REQ-024 mem_ready in IDLE or DONE SHALL be ignored.
REQ-025 Minimum latency: request at cycle t → mem_* at t+1; with mem_ready at t+1, client ready at t+1; next grant possible at t+3.

Reset
REQ-026 proc_reset_n=0 SHALL asynchronously force state IDLE, last-served=I, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0; i_mem_ready and d_mem_ready are then 0.
REQ-027 Reset mid-transaction SHALL abandon the request; a later mem_ready before any new grant is ignored per REQ-024.

Structure
REQ-028 Shared package SHALL hold the state enum and default ADDR_W/DATA_W constants, reused by I_cache/D_cache integration.
REQ-029 Single module; no sub-module is natural at this size.

Verification
REQ-030 I read only, addr 0x0000010, memory ready after 3 cycles with data 0xA5..A5 → mem_read held 3 cycles with mem_addr 0x0000010, i_mem_ready one cycle, i_mem_rdata=0xA5..A5, d_mem_ready=0.
REQ-031 I and D reads in the same cycle right after reset → D served first, then I, with exactly one DONE cycle between.
REQ-032 D read+write together, addr 0x0ABCDEF, wdata 0x1234..  → mem_write=1, mem_read=0, mem_wdata=0x1234..
REQ-033 D changes d_mem_addr mid-BUSY_D from 0x1 to 0x2 → mem_addr stays 0x1 until mem_ready.
REQ-034 proc_reset_n low during BUSY_I, then a spurious mem_ready after release → all outputs 0, no ready pulse to either client.
REQ-035 Both ports request continuously for 6 transactions → grants alternate D,I,D,I,D,I.
